// File: rtl/operand_fetch.sv
// Operand fetch stage: 32-entry architectural register file with write-back bypass
// on both read ports, feeding a stallable/flushable operand pipeline register.
module operand_fetch #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [ADDR_W-1:0] rs_addr_q,
    output logic [ADDR_W-1:0] rt_addr_q,
    output logic              out_valid
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              wb_live;

    // Register 0 is never written nor forwarded, so a zero destination is a dead write.
    assign wb_live = wb_we && (wb_addr != '0);

    always_comb begin
        rs_fwd = '0;
        if (rs_addr != '0) begin
            if (wb_live && (wb_addr == rs_addr)) rs_fwd = wb_data;
            else                                 rs_fwd = regs[rs_addr];
        end
    end

    always_comb begin
        rt_fwd = '0;
        if (rt_addr != '0) begin
            if (wb_live && (wb_addr == rt_addr)) rt_fwd = wb_data;
            else                                 rt_fwd = regs[rt_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (enable && wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rs_data   <= '0;
            rt_data   <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            out_valid <= 1'b0;
        end else if (enable) begin
            if (flush) begin
                rs_data   <= '0;
                rt_data   <= '0;
                rs_addr_q <= '0;
                rt_addr_q <= '0;
                out_valid <= 1'b0;
            end else if (stall) begin
                // Held operands track write-backs to their register so they are not stale on release.
                if (wb_live && (wb_addr == rs_addr_q)) rs_data <= wb_data;
                if (wb_live && (wb_addr == rt_addr_q)) rt_data <= wb_data;
            end else begin
                rs_data   <= rs_fwd;
                rt_data   <= rt_fwd;
                rs_addr_q <= rs_addr;
                rt_addr_q <= rt_addr;
                out_valid <= in_valid;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// checked against a behavioural register-file/pipeline model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs_addr_q;
    logic [4:0]  rt_addr_q;
    logic        out_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state
    logic [31:0] m_rf [32];
    logic [31:0] m_rs_data, m_rt_data;
    logic [4:0]  m_rs_q, m_rt_q;
    logic        m_valid;

    operand_fetch #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .in_valid(in_valid),
        .stall(stall), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data),
        .rs_addr_q(rs_addr_q), .rt_addr_q(rt_addr_q), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        logic [31:0] n_rs, n_rt;
        logic [4:0]  n_rsq, n_rtq;
        logic        n_v;
        logic        do_wr;
        n_rs = m_rs_data; n_rt = m_rt_data; n_rsq = m_rs_q; n_rtq = m_rt_q; n_v = m_valid;
        do_wr = 1'b0;
        if (!reset) begin
            n_rs = 0; n_rt = 0; n_rsq = 0; n_rtq = 0; n_v = 0;
        end else if (enable) begin
            do_wr = wb_we && (wb_addr != 5'd0);
            if (flush) begin
                n_rs = 0; n_rt = 0; n_rsq = 0; n_rtq = 0; n_v = 0;
            end else if (stall) begin
                if (do_wr && wb_addr == m_rs_q) n_rs = wb_data;
                if (do_wr && wb_addr == m_rt_q) n_rt = wb_data;
            end else begin
                n_rs = model_read(rs_addr); n_rt = model_read(rt_addr);
                n_rsq = rs_addr; n_rtq = rt_addr; n_v = in_valid;
            end
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (do_wr) begin
            m_rf[wb_addr] = wb_data;
        end
        m_rs_data = n_rs; m_rt_data = n_rt; m_rs_q = n_rsq; m_rt_q = n_rtq; m_valid = n_v;
    endtask

    task automatic idle_inputs();
        enable = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
        rs_addr = 0; rt_addr = 0; in_valid = 0; stall = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0; enable = 0; wb_we = 1; wb_addr = 5'd3; wb_data = 32'hFFFF_FFFF;
        tick();
        tests_run++;
        if ({out_valid, rs_data, rt_data, rs_addr_q, rt_addr_q} !== 75'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b rs=%h rt=%h rsq=%0d rtq=%0d, want all 0",
                     out_valid, rs_data, rt_data, rs_addr_q, rt_addr_q);
        end
        reset = 1; idle_inputs();
        rs_addr = 5'd3; rt_addr = 5'd31; in_valid = 1;
        tick();
        tests_run++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_read: got rs=%h rt=%h v=%b, want 0 0 1", rs_data, rt_data, out_valid);
        end
    endtask

    task automatic test_write_readback();
        idle_inputs();
        wb_we = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_addr = 5'd0; wb_data = 32'h1234;
        tick();
        idle_inputs();
        rs_addr = 5'd5; rt_addr = 5'd0; in_valid = 1;
        tick();
        tests_run++;
        if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL write_r0: got rs=%h rt=%h, want deadbeef 0", rs_data, rt_data);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        wb_we = 1; wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5;
        rs_addr = 5'd7; rt_addr = 5'd7; in_valid = 1;
        tick();
        tests_run++;
        if (rs_data !== 32'hA5A5_A5A5 || rt_data !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL bypass_same: got rs=%h rt=%h, want a5a5a5a5 both", rs_data, rt_data);
        end
        idle_inputs();
        rs_addr = 5'd3; rt_addr = 5'd7; in_valid = 1;
        tick();
        tests_run++;
        if (rt_data !== 32'hA5A5_A5A5 || rt_addr_q !== 5'd7) begin
            tests_failed++;
            $display("FAIL bypass_later: got rt=%h rtq=%0d, want a5a5a5a5 7", rt_data, rt_addr_q);
        end
    endtask

    task automatic test_stall_refresh();
        idle_inputs();
        wb_we = 1; wb_addr = 5'd9; wb_data = 32'd1;
        tick();
        idle_inputs();
        rs_addr = 5'd9; rt_addr = 5'd5; in_valid = 1;
        tick();
        tests_run++;
        if (rs_data !== 32'd1) begin
            tests_failed++;
            $display("FAIL stall_latch: got rs=%h want 1", rs_data);
        end
        stall = 1; rs_addr = 5'd1; rt_addr = 5'd2; in_valid = 0;
        tick();
        wb_we = 1; wb_addr = 5'd9; wb_data = 32'h55;
        tick();
        tests_run++;
        if (rs_data !== 32'h55 || rs_addr_q !== 5'd9 || out_valid !== 1'b1 || rt_data !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL stall_refresh: got rs=%h rsq=%0d v=%b rt=%h, want 55 9 1 deadbeef",
                     rs_data, rs_addr_q, out_valid, rt_data);
        end
        wb_we = 0;
        tick();
        tests_run++;
        if (rs_data !== 32'h55 || rt_addr_q !== 5'd5) begin
            tests_failed++;
            $display("FAIL stall_hold: got rs=%h rtq=%0d, want 55 5", rs_data, rt_addr_q);
        end
        stall = 0;
    endtask

    task automatic test_flush();
        idle_inputs();
        rs_addr = 5'd5; rt_addr = 5'd9; in_valid = 1;
        tick();
        stall = 1; flush = 1; wb_we = 1; wb_addr = 5'd12; wb_data = 32'hCAFE;
        tick();
        tests_run++;
        if ({out_valid, rs_data, rt_data, rs_addr_q, rt_addr_q} !== 75'd0) begin
            tests_failed++;
            $display("FAIL flush_prio: got v=%b rs=%h rt=%h rsq=%0d rtq=%0d, want all 0",
                     out_valid, rs_data, rt_data, rs_addr_q, rt_addr_q);
        end
        idle_inputs();
        rs_addr = 5'd12; in_valid = 1;
        tick();
        tests_run++;
        if (rs_data !== 32'hCAFE) begin
            tests_failed++;
            $display("FAIL flush_write: got rs=%h want cafe", rs_data);
        end
    endtask

    task automatic test_enable_reset();
        idle_inputs();
        wb_we = 1; wb_addr = 5'd4; wb_data = 32'h44;
        tick();
        idle_inputs();
        rs_addr = 5'd4; rt_addr = 5'd5; in_valid = 1;
        tick();
        enable = 0; wb_we = 1; wb_addr = 5'd4; wb_data = 32'h99;
        rs_addr = 5'd9; rt_addr = 5'd12; in_valid = 0; flush = 1;
        tick();
        tests_run++;
        if (rs_data !== 32'h44 || rt_data !== 32'hDEAD_BEEF || out_valid !== 1'b1 || rs_addr_q !== 5'd4) begin
            tests_failed++;
            $display("FAIL enable_freeze: got rs=%h rt=%h v=%b rsq=%0d, want 44 deadbeef 1 4",
                     rs_data, rt_data, out_valid, rs_addr_q);
        end
        idle_inputs();
        rs_addr = 5'd4; rt_addr = 5'd5; in_valid = 1;
        tick();
        tests_run++;
        if (rs_data !== 32'h44) begin
            tests_failed++;
            $display("FAIL enable_nowrite: got r4=%h want 44", rs_data);
        end
        stall = 1; reset = 0; wb_we = 1; wb_addr = 5'd5; wb_data = 32'h77;
        tick();
        tests_run++;
        if ({out_valid, rs_data, rt_data, rs_addr_q, rt_addr_q} !== 75'd0) begin
            tests_failed++;
            $display("FAIL reset_stall: got v=%b rs=%h rt=%h rsq=%0d rtq=%0d, want all 0",
                     out_valid, rs_data, rt_data, rs_addr_q, rt_addr_q);
        end
        reset = 1; idle_inputs();
        rs_addr = 5'd5; rt_addr = 5'd4; in_valid = 1;
        tick();
        tests_run++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_clears: got r5=%h r4=%h want 0 0", rs_data, rt_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 59) != 0);
            enable   = ($urandom_range(0, 9) != 0);
            wb_we    = ($urandom_range(0, 2) != 0);
            wb_data  = $urandom;
            in_valid = 1'($urandom_range(0, 1));
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) begin
                wb_addr = 5'($urandom_range(0, 3));
                rs_addr = 5'($urandom_range(0, 3));
                rt_addr = 5'($urandom_range(0, 3));
            end else begin
                wb_addr = 5'($urandom_range(0, 31));
                rs_addr = 5'($urandom_range(0, 31));
                rt_addr = 5'($urandom_range(0, 31));
            end
            tick();
            tests_run++;
            if (rs_data !== m_rs_data || rt_data !== m_rt_data || rs_addr_q !== m_rs_q ||
                rt_addr_q !== m_rt_q || out_valid !== m_valid) begin
                tests_failed++;
                $display("FAIL random[%0d]: got rs=%h rt=%h rsq=%0d rtq=%0d v=%b, want rs=%h rt=%h rsq=%0d rtq=%0d v=%b",
                         n, rs_data, rt_data, rs_addr_q, rt_addr_q, out_valid,
                         m_rs_data, m_rt_data, m_rs_q, m_rt_q, m_valid);
            end
        end
        reset = 1;
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_write_readback();
        test_bypass();
        test_stall_refresh();
        test_flush();
        test_enable_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
